// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit scan with ghost blanking,
// frame-synchronous double-buffered display data, per-digit mask and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int DIV_MAX   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       hexs,
  input  logic [DIGITS-1:0]         point,
  input  logic [DIGITS-1:0]         les,
  input  logic [DIGITS-1:0]         dig_en,
  input  logic                      lz_en,
  output logic [3:0]                hex_o,
  output logic                      dp_o,
  output logic                      le_o,
  output logic [DIGITS-1:0]         an_o,
  output logic [$clog2(DIGITS)-1:0] scan_o,
  output logic                      frame_tick,
  output logic                      load_pend
);

  localparam int IW   = $clog2(DIGITS);
  localparam int CMAX = (DIV_MAX > BLANK_CYC) ? DIV_MAX : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV_MAX - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  typedef struct packed {
    logic [4*DIGITS-1:0] hex;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   le;
    logic [DIGITS-1:0]   ena;
  } disp_t;

  state_t          state, nstate;
  logic [IW-1:0]   idx, nidx;
  logic [CW-1:0]   cyc, ncyc;
  disp_t           staging, shadow, nshadow;
  logic            frame_end, commit, run;
  logic [DIGITS-1:0] lead_zero, vis, nan;

  always_comb begin
    frame_end = (state == SHOW) && (cyc == SHOW_LAST) && (idx == IDX_LAST);
    commit    = load_pend && ((state == IDLE) || frame_end);
    nstate    = state;
    nidx      = idx;
    ncyc      = cyc;
    if (!en) begin
      nstate = IDLE;
      nidx   = '0;
      ncyc   = '0;
    end else begin
      case (state)
        IDLE: begin
          nstate = (BLANK_CYC > 0) ? BLANK : SHOW;
          nidx   = '0;
          ncyc   = '0;
        end
        BLANK: begin
          if (cyc == BLANK_LAST) begin
            nstate = SHOW;
            ncyc   = '0;
          end else begin
            ncyc = cyc + 1'b1;
          end
        end
        SHOW: begin
          if (cyc == SHOW_LAST) begin
            nstate = (BLANK_CYC > 0) ? BLANK : SHOW;
            nidx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            ncyc   = '0;
          end else begin
            ncyc = cyc + 1'b1;
          end
        end
        default: begin
          nstate = IDLE;
          nidx   = '0;
          ncyc   = '0;
        end
      endcase
    end

    nshadow = commit ? staging : shadow;

    // lead_zero[k]: nibbles DIGITS-1 down to k are all zero
    run = 1'b1;
    lead_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run & (nshadow.hex[4*k +: 4] == 4'h0);
      lead_zero[k] = run;
    end
    vis = nshadow.ena & ~({DIGITS{lz_en}} & lead_zero & ~DIGITS'(1));

    nan = '1;
    if (nstate == SHOW && vis[nidx]) nan[nidx] = 1'b0;
  end

  // Outputs are driven from next-state values so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cyc        <= '0;
      staging    <= '0;
      shadow     <= '0;
      load_pend  <= 1'b0;
      an_o       <= '1;
      hex_o      <= 4'h0;
      dp_o       <= 1'b0;
      le_o       <= 1'b0;
      scan_o     <= '0;
      frame_tick <= 1'b0;
    end else begin
      state  <= nstate;
      idx    <= nidx;
      cyc    <= ncyc;
      shadow <= nshadow;
      if (load) begin
        staging   <= '{hex: hexs, dp: point, le: les, ena: dig_en};
        load_pend <= 1'b1;
      end else if (commit) begin
        load_pend <= 1'b0;
      end
      an_o       <= nan;
      hex_o      <= nshadow.hex[4*nidx +: 4];
      dp_o       <= nshadow.dp[nidx];
      le_o       <= nshadow.le[nidx];
      scan_o     <= nidx;
      frame_tick <= frame_end && en;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-position reference model predicts outputs each cycle.
module tb_seg_scan_ctrl;
  localparam int D = 8, DV = 4, BL = 2, SLOT = BL + DV, FRAME = D * SLOT;

  logic        clk, rst_n, en, load, lz_en;
  logic [31:0] hexs;
  logic [7:0]  point, les, dig_en;
  logic [3:0]  hex_o;
  logic        dp_o, le_o, frame_tick, load_pend;
  logic [7:0]  an_o;
  logic [2:0]  scan_o;

  seg_scan_ctrl #(.DIGITS(D), .DIV_MAX(DV), .BLANK_CYC(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .hexs(hexs), .point(point),
    .les(les), .dig_en(dig_en), .lz_en(lz_en), .hex_o(hex_o), .dp_o(dp_o),
    .le_o(le_o), .an_o(an_o), .scan_o(scan_o), .frame_tick(frame_tick),
    .load_pend(load_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] hex;
    logic       dp;
    logic       le;
    logic [7:0] an;
    logic [2:0] scan;
    logic       tick;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_bad = 0;

  // Reference model: position within the frame since scanning started
  bit          running;
  int          pos;
  bit          pend;
  logic [31:0] s_hex, m_hex;
  logic [7:0]  s_dp, m_dp, s_le, m_le, s_en, m_en;

  always @(posedge clk) begin
    exp_t e;
    bit   bnd, cmt, nrun, show, vis, allz;
    int   npos, idx;
    e = '0;
    if (!rst_n) begin
      running = 0; pos = 0; pend = 0;
      s_hex = 0; m_hex = 0; s_dp = 0; m_dp = 0; s_le = 0; m_le = 0; s_en = 0; m_en = 0;
      e.an = 8'hFF;
    end else begin
      bnd    = running && (pos == FRAME - 1);
      cmt    = pend && (!running || bnd);
      e.tick = running && en && bnd;
      npos = 0;
      nrun = 0;
      if (en) begin
        nrun = 1;
        npos = running ? (pos + 1) % FRAME : 0;
      end
      if (cmt) begin
        m_hex = s_hex; m_dp = s_dp; m_le = s_le; m_en = s_en;
      end
      if (load) begin
        s_hex = hexs; s_dp = point; s_le = les; s_en = dig_en; pend = 1;
      end else if (cmt) begin
        pend = 0;
      end
      running = nrun;
      pos     = npos;
      idx  = running ? pos / SLOT : 0;
      show = running && ((pos % SLOT) >= BL);
      vis  = m_en[idx];
      if (lz_en && idx != 0) begin
        allz = 1;
        for (int j = idx; j < D; j++) if (m_hex[4*j +: 4] != 4'h0) allz = 0;
        if (allz) vis = 0;
      end
      e.an   = (show && vis) ? ~(8'b1 << idx) : 8'hFF;
      e.hex  = m_hex[4*idx +: 4];
      e.dp   = m_dp[idx];
      e.le   = m_le[idx];
      e.scan = idx[2:0];
      e.pend = pend;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e, got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {hex_o, dp_o, le_o, an_o, scan_o, frame_tick, load_pend};
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t got hex=%h dp=%b le=%b an=%h scan=%0d tick=%b pend=%b, want hex=%h dp=%b le=%b an=%h scan=%0d tick=%b pend=%b",
                 $time, got.hex, got.dp, got.le, got.an, got.scan, got.tick, got.pend,
                 e.hex, e.dp, e.le, e.an, e.scan, e.tick, e.pend);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
                         input logic [7:0] m);
    hexs = h; point = p; les = l; dig_en = m; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1;
    end
    #1;
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL frame_tick_timeout got none within %0d cycles, want one", 3 * FRAME);
    end
  endtask

  initial begin
    rst_n = 0; en = 0; load = 0; lz_en = 0;
    hexs = 0; point = 0; les = 0; dig_en = 0;
    step(3);
    rst_n = 1;
    step(2);

    // load while idle, then scan
    do_load(32'h76543210, 8'h0F, 8'h33, 8'hFF);
    en = 1;
    step(2 * FRAME + 4);

    // mid-frame load at index 3
    wait_tick();
    step(3 * SLOT + 3);
    do_load(32'hAAAAAAAA, 8'hF0, 8'h5A, 8'hFF);
    step(2 * FRAME);

    // leading-zero suppression
    lz_en = 1;
    do_load(32'h00000050, 8'h00, 8'h00, 8'hFF);
    step(2 * FRAME);
    do_load(32'h00000000, 8'h81, 8'h18, 8'hFF);
    step(2 * FRAME);

    // digit mask
    lz_en = 0;
    do_load(32'h89ABCDEF, 8'h55, 8'hAA, 8'hAA);
    step(2 * FRAME);

    // load on the exact commit edge
    wait_tick();
    do_load(32'h13579BDF, 8'h11, 8'h22, 8'hFF);
    step(FRAME - 2);
    do_load(32'hBBBBBBBB, 8'hCC, 8'h33, 8'h7E);
    step(2 * FRAME + 3);

    // async reset mid-SHOW of index 5
    wait_tick();
    step(5 * SLOT + 3);
    #1;
    rst_n = 0;
    #1;
    n_vec++;
    if (an_o !== 8'hFF || hex_o !== 4'h0 || scan_o !== 3'd0 || frame_tick !== 1'b0 ||
        load_pend !== 1'b0 || dp_o !== 1'b0 || le_o !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got an=%h hex=%h scan=%0d tick=%b pend=%b, want an=ff hex=0 scan=0 tick=0 pend=0",
               an_o, hex_o, scan_o, frame_tick, load_pend);
    end
    step(2);
    rst_n = 1;

    // en drop mid-frame
    do_load(32'hFEDCBA98, 8'h3C, 8'hC3, 8'hFF);
    step(20);
    en = 0;
    step(3);
    en = 1;
    step(FRAME + 10);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        hexs   = $urandom & (($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : (32'hFFFFFFFF >> (4 * $urandom_range(1, 8))));
        point  = 8'($urandom);
        les    = 8'($urandom);
        dig_en = 8'($urandom);
        load   = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      en = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    load = 0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
